pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
- Frame-level scheduler for the ray-tracing cores.
- Walks pixel coordinates in raster order and hands one pixel job at a time to cores 1..N in strict round-robin order. This matches the in-order collection order of the downstream pixel reorder buffer.
- Counts pixels leaving the buffer to generate stream sideband (start-of-frame, end-of-line) and a frame-done pulse.
- Sits between the host/config registers and the core array plus pixel buffer.

Parameters:
- CW, 12, width of coordinate and dimension fields (max 4095 x 4095).
- NCORE, 4, number of physical core job ports.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous reset, active-low
- start  in  1  pulse; begin a frame (honoured only in IDLE)
- cfg_width  in  CW  pixels per line, sampled at start
- cfg_height  in  CW  lines per frame, sampled at start
- no_of_extra_cores  in  3  active cores minus 1, sampled at start; values >3 are treated as 3
- job_valid  out  NCORE  one-hot job offer to core i
- job_ready  in  NCORE  core i accepts job
- job_x  out  CW  shared pixel x of the offered job
- job_y  out  CW  shared pixel y of the offered job
- pix_accept  in  1  pixel buffer output handshake (out_valid & in_stream_ready)
- out_sof  out  1  current outgoing pixel is pixel (0,0)
- out_eol  out  1  current outgoing pixel is the last pixel of its line
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: job_valid=0, job_x=0, job_y=0, busy=0, frame_done=0. All counters are 0, cursor=0, state IDLE.
- States:
  - IDLE: on start, latch the config and go to DISPATCH. If the latched width or height is 0, go to DONE instead.
  - DISPATCH: job_valid[cursor]=1 with the current x,y. On job_ready[cursor]:
    - x increments; if x==W-1, x returns to 0 and y increments.
    - cursor = (cursor+1) mod ncore, where ncore = min(extra,3)+1.
    - If the accepted job was (W-1,H-1), go to DRAIN.
  - DRAIN: wait until the emitted count equals W*H, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- Job handshake:
  - Valid and ready, AXI-style. Once job_valid[i] rises, it and x,y stay stable until job_ready[i].
  - job_ready on a non-selected port is ignored.
  - One job transfers per cycle at most. Back-to-back acceptance gives 1 job/cycle.
- Emit tracking:
  - Counters ex,ey advance on every pix_accept in DISPATCH or DRAIN, with the same wrap as x,y.
  - The emitted-pixel counter is 2*CW bits wide. The total W*H is computed once at start.
  - pix_accept is ignored in IDLE and DONE.
- Sideband (combinational from the emit counters):
  - out_sof = busy & ex==0 & ey==0.
  - out_eol = busy & ex==W-1.
- Simultaneous events:
  - A job acceptance and a pix_accept in the same cycle both take effect.
  - The final pix_accept may arrive in the same cycle DISPATCH accepts the final job only if the design is inconsistent. In that case DISPATCH still goes to DRAIN, which exits next cycle.
- Config changes while busy have no effect until the next start. A start while busy is ignored.
- Reset mid-frame: everything returns to reset values immediately. No partial frame_done is generated.
- Latency: start to first job_valid is 1 cycle. The last pix_accept to frame_done is 2 cycles (DRAIN detect, then DONE).

Optional Feature:
- Macro DISPATCH_PERF_EN.
- When defined, adds outputs perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles counts cycles from start to frame_done.
  - perf_stall counts DISPATCH cycles where job_valid is high and job_ready[cursor] is low.
  - Both clear at start and hold after DONE. Both are 0 on reset.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Width 4, height 2, extra=3, all job_ready high. Jobs (0,0)..(3,1) go to cores 0,1,2,3,0,1,2,3 on consecutive cycles, then DRAIN. 8 pix_accepts give out_sof on the 1st, out_eol on the 4th and 8th, and frame_done 2 cycles after the 8th.
- Width 3, height 1, extra=1. The cursor sequence is 0,1,0. job_valid[2] and job_valid[3] never assert.
- extra=6, width 5, height 1. Same as extra=3: the cursor wraps after 3.
- Hold job_ready[1] low for 5 cycles while job_valid[1] is high. job_x/job_y stay stable, no other job_valid rises, and perf_stall=5 (with DISPATCH_PERF_EN).
- Width 0, height 7, start. busy lasts 1 cycle, frame_done pulses once, no job_valid.
- Assert aresetn low mid-DISPATCH. All outputs return to 0 and there is no frame_done. A subsequent start re-runs the frame from (0,0) with cursor 0.

Source files
------------

// File: rtl/pixel_dispatcher_if.sv
// Job-port bundle between the pixel dispatcher and the ray-tracing core array.
// Handshake: a job moves on core i in any cycle where job_valid[i] and
// job_ready[i] are both high at the rising edge of aclk. Once job_valid[i]
// rises, it stays high and job_x/job_y stay stable until that transfer.
// job_valid is one-hot or zero. Ready on a port that is not offered a job
// has no effect.
interface pixel_dispatcher_if #(
  parameter int CW    = 12,
  parameter int NCORE = 4
);
  logic [NCORE-1:0] job_valid;
  logic [NCORE-1:0] job_ready;
  logic [CW-1:0]    job_x;
  logic [CW-1:0]    job_y;

  modport master (output job_valid, output job_x, output job_y, input job_ready);
  modport slave  (input job_valid, input job_x, input job_y, output job_ready);
endinterface

// File: rtl/pixel_dispatcher.sv
// Frame-level scheduler for the ray-tracing cores. It walks pixels in raster
// order, offers one job at a time to cores in strict round-robin order, and
// tracks pixels leaving the reorder buffer to produce SOF/EOL sideband and a
// frame_done pulse.
// Optional feature: define DISPATCH_PERF_EN to add perf_cycles/perf_stall.
module pixel_dispatcher #(
  parameter int CW    = 12,
  parameter int NCORE = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic [CW-1:0]   cfg_width,
  input  logic [CW-1:0]   cfg_height,
  input  logic [2:0]      no_of_extra_cores,
  pixel_dispatcher_if.master job,
  input  logic            pix_accept,
  output logic            out_sof,
  output logic            out_eol,
  output logic            busy,
  output logic            frame_done,
  output logic [1:0]      dbg_state
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CURW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int MAXC = (NCORE < 4) ? NCORE - 1 : 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     w_q, h_q;
  logic [CURW-1:0]   last_cur;
  logic [CURW-1:0]   cursor;
  logic [2*CW-1:0]   total;
  logic [2*CW-1:0]   emitted;
  logic [CW-1:0]     x, y, ex, ey;
  logic [2:0]        ext_clamped;
  logic              launch, job_acc, emit_acc;
  logic              x_last, y_last, ex_last, ey_last;

  // Clamp the extra-core count to the cores that physically exist.
  assign ext_clamped = (no_of_extra_cores > 3'(MAXC)) ? 3'(MAXC) : no_of_extra_cores;

  assign launch   = (state == IDLE) && start;
  assign job_acc  = (state == DISPATCH) && job.job_ready[cursor];
  assign emit_acc = pix_accept && ((state == DISPATCH) || (state == DRAIN));
  assign x_last   = (x == w_q - CW'(1));
  assign y_last   = (y == h_q - CW'(1));
  assign ex_last  = (ex == w_q - CW'(1));
  assign ey_last  = (ey == h_q - CW'(1));

  assign busy      = (state != IDLE);
  assign out_sof   = busy && (ex == '0) && (ey == '0);
  assign out_eol   = busy && ex_last;
  assign job.job_x = x;
  assign job.job_y = y;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic, one-hot job offer and the frame_done pulse.
  always_comb begin
    state_d       = state;
    frame_done    = 1'b0;
    job.job_valid = '0;
    case (state)
      IDLE: begin
        if (start) state_d = ((cfg_width == '0) || (cfg_height == '0)) ? DONE : DISPATCH;
      end
      DISPATCH: begin
        job.job_valid[cursor] = 1'b1;
        if (job_acc && x_last && y_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (emitted == total) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config latch, job cursor/coordinates and emit counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_q      <= '0;
      h_q      <= '0;
      last_cur <= '0;
      total    <= '0;
      x        <= '0;
      y        <= '0;
      cursor   <= '0;
      ex       <= '0;
      ey       <= '0;
      emitted  <= '0;
    end else if (launch) begin
      w_q      <= cfg_width;
      h_q      <= cfg_height;
      last_cur <= ext_clamped[CURW-1:0];
      total    <= (2*CW)'(cfg_width) * (2*CW)'(cfg_height);
      x        <= '0;
      y        <= '0;
      cursor   <= '0;
      ex       <= '0;
      ey       <= '0;
      emitted  <= '0;
    end else begin
      if (job_acc) begin
        x      <= x_last ? '0 : x + CW'(1);
        if (x_last) y <= y_last ? '0 : y + CW'(1);
        cursor <= (cursor == last_cur) ? '0 : cursor + CURW'(1);
      end
      if (emit_acc) begin
        ex      <= ex_last ? '0 : ex + CW'(1);
        if (ex_last) ey <= ey_last ? '0 : ey + CW'(1);
        emitted <= emitted + (2*CW)'(1);
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  // Frame cycle count and dispatch stall count; cleared at start, held after DONE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (launch) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if ((state == DISPATCH) && !job.job_ready[cursor]) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher: per-scenario tasks with a job
// scoreboard (core, x, y) and an emit scoreboard (sof, eol).
module tb_pixel_dispatcher;
  localparam int CW    = 12;
  localparam int NCORE = 4;
  localparam int JW    = 2 + 2*CW;

  logic            aclk;
  logic            aresetn;
  logic            start;
  logic [CW-1:0]   cfg_width;
  logic [CW-1:0]   cfg_height;
  logic [2:0]      no_of_extra_cores;
  logic            pix_accept;
  logic            out_sof;
  logic            out_eol;
  logic            busy;
  logic            frame_done;
  logic [1:0]      dbg_state;
`ifdef DISPATCH_PERF_EN
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_stall;
`endif

  pixel_dispatcher_if #(.CW(CW), .NCORE(NCORE)) job_if ();

  pixel_dispatcher #(.CW(CW), .NCORE(NCORE)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .no_of_extra_cores (no_of_extra_cores),
    .job               (job_if.master),
    .pix_accept        (pix_accept),
    .out_sof           (out_sof),
    .out_eol           (out_eol),
    .busy              (busy),
    .frame_done        (frame_done),
    .dbg_state         (dbg_state)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_cycles       (perf_cycles),
    .perf_stall        (perf_stall)
`endif
  );

  // Clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [JW-1:0] exp_q[$];
  logic [1:0]    exp_e_q[$];

  task automatic test_reset();
    aresetn = 1'b0;
    start = 1'b0; pix_accept = 1'b0; job_if.job_ready = '0;
    cfg_width = '0; cfg_height = '0; no_of_extra_cores = '0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if (job_if.job_valid !== '0 || job_if.job_x !== '0 || job_if.job_y !== '0)
      $display("FAIL reset_job: valid=%h x=%0d y=%0d expected all 0", job_if.job_valid, job_if.job_x, job_if.job_y);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0/0/0", busy, frame_done, dbg_state);
    else n_pass++;
`ifdef DISPATCH_PERF_EN
    n_checks++;
    if (perf_cycles !== 32'd0 || perf_stall !== 32'd0)
      $display("FAIL reset_perf: cycles=%0d stall=%0d expected 0/0", perf_cycles, perf_stall);
    else n_pass++;
`endif
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b expected 0", busy);
    else n_pass++;
  endtask

  // Runs one frame. mode 0: all ready; 1: random ready/accept/start/cfg noise;
  // 2: hold job_ready[1] low for 5 cycles while core 1 is offered a job.
  task automatic run_frame(input int w, input int h, input int extra, input int mode, input string name);
    int nc, acc, emit, done_seen, done_cyc, last_emit_cyc, busy_cyc, stall_cyc, stall_left;
    int first_acc, last_acc, k;
    logic [JW-1:0]    head;
    logic [NCORE-1:0] exp_v;
    logic [1:0]       eh;
    nc = ((extra > 3) ? 3 : extra) + 1;
    exp_q.delete(); exp_e_q.delete();
    k = 0;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        exp_q.push_back({2'(k % nc), CW'(xx), CW'(yy)});
        exp_e_q.push_back({(xx == 0 && yy == 0), (xx == w - 1)});
        k++;
      end
    acc = 0; emit = 0; done_seen = 0; done_cyc = -1; last_emit_cyc = -1;
    busy_cyc = 0; stall_cyc = 0; stall_left = (mode == 2) ? 5 : 0;
    first_acc = -1; last_acc = -1;

    cfg_width = CW'(w); cfg_height = CW'(h); no_of_extra_cores = 3'(extra);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (busy) busy_cyc++;
      if (frame_done) begin
        done_seen++;
        if (done_seen == 1) done_cyc = cyc;
      end
      if (cyc == 0) begin
        n_checks++;
        if (k == 0) begin
          if (frame_done !== 1'b1 || job_if.job_valid !== '0)
            $display("FAIL %s_empty_done: done=%b valid=%h expected 1/0", name, frame_done, job_if.job_valid);
          else n_pass++;
        end else begin
          if (job_if.job_valid !== NCORE'(1))
            $display("FAIL %s_latency: valid=%h expected 1", name, job_if.job_valid);
          else n_pass++;
        end
      end
      if (done_seen > 0 && cyc == done_cyc + 2) break;

      // Drive inputs for the coming edge; DUT outputs do not depend on them.
      cfg_width = CW'($urandom_range(0, 4095));
      cfg_height = CW'($urandom_range(0, 4095));
      no_of_extra_cores = 3'($urandom_range(0, 7));
      pix_accept = (emit < acc) && (mode != 1 || $urandom_range(0, 1) == 1);
      start = (mode == 1) && busy && !frame_done && ($urandom_range(0, 5) == 0);
      if (mode == 1) job_if.job_ready = NCORE'($urandom_range(0, 15));
      else begin
        job_if.job_ready = '1;
        if (mode == 2 && job_if.job_valid[1] && stall_left > 0) begin
          job_if.job_ready[1] = 1'b0;
          stall_left--;
        end
      end

      if (job_if.job_valid !== '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_job: valid=%h expected none", name, job_if.job_valid);
        end else begin
          head = exp_q[0];
          exp_v = '0;
          exp_v[head[JW-1 -: 2]] = 1'b1;
          if (job_if.job_valid !== exp_v || job_if.job_x !== head[2*CW-1 -: CW] || job_if.job_y !== head[CW-1:0])
            $display("FAIL %s_job: valid=%h x=%0d y=%0d expected valid=%h x=%0d y=%0d", name,
                     job_if.job_valid, job_if.job_x, job_if.job_y, exp_v, head[2*CW-1 -: CW], head[CW-1:0]);
          else n_pass++;
          if ((job_if.job_valid & job_if.job_ready) != '0) begin
            void'(exp_q.pop_front());
            acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
          end else stall_cyc++;
        end
      end
      if (pix_accept) begin
        eh = exp_e_q.pop_front();
        n_checks++;
        if (out_sof !== eh[1] || out_eol !== eh[0])
          $display("FAIL %s_sideband: pixel %0d sof=%b eol=%b expected sof=%b eol=%b", name, emit, out_sof, out_eol, eh[1], eh[0]);
        else n_pass++;
        emit++;
        last_emit_cyc = cyc;
      end
      @(negedge aclk);
    end
    pix_accept = 1'b0; job_if.job_ready = '0; start = 1'b0;

    n_checks++;
    if (done_seen != 1) $display("FAIL %s_done_count: saw %0d pulses expected 1", name, done_seen);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || exp_e_q.size() != 0 || acc != k || emit != k)
      $display("FAIL %s_totals: jobs=%0d pixels=%0d expected %0d", name, acc, emit, k);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b expected 0", name, busy);
    else n_pass++;
    if (k > 0) begin
      n_checks++;
      if (done_cyc - last_emit_cyc != 2)
        $display("FAIL %s_done_latency: %0d cycles expected 2", name, done_cyc - last_emit_cyc);
      else n_pass++;
    end else begin
      n_checks++;
      if (busy_cyc != 1) $display("FAIL %s_busy_len: %0d cycles expected 1", name, busy_cyc);
      else n_pass++;
    end
    if (mode == 0 && k > 0) begin
      n_checks++;
      if (last_acc - first_acc != k - 1)
        $display("FAIL %s_back_to_back: span=%0d expected %0d", name, last_acc - first_acc, k - 1);
      else n_pass++;
    end
    if (mode == 2) begin
      n_checks++;
      if (stall_cyc != 5) $display("FAIL %s_stall_cycles: %0d expected 5", name, stall_cyc);
      else n_pass++;
    end
`ifdef DISPATCH_PERF_EN
    n_checks++;
    if (perf_cycles !== 32'(busy_cyc) || perf_stall !== 32'(stall_cyc))
      $display("FAIL %s_perf: cycles=%0d stall=%0d expected %0d/%0d", name, perf_cycles, perf_stall, busy_cyc, stall_cyc);
    else n_pass++;
`endif
  endtask

  task automatic test_raster_4x2();     run_frame(4, 2, 3, 0, "raster_4x2");  endtask
  task automatic test_two_cores();      run_frame(3, 1, 1, 0, "two_cores");   endtask
  task automatic test_extra_clamp();    run_frame(5, 1, 6, 0, "extra_clamp"); endtask
  task automatic test_stall();          run_frame(4, 2, 3, 2, "stall");       endtask
  task automatic test_random();         run_frame(6, 3, 2, 1, "random");      endtask
  task automatic test_zero_width();     run_frame(0, 7, 3, 0, "zero_width");  endtask

  task automatic test_reset_mid_frame();
    int dones;
    cfg_width = CW'(4); cfg_height = CW'(2); no_of_extra_cores = 3'd3;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    job_if.job_ready = '1;
    repeat (2) @(negedge aclk);
    job_if.job_ready = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (job_if.job_valid !== '0 || job_if.job_x !== '0 || job_if.job_y !== '0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || out_sof !== 1'b0 || out_eol !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL midreset_outputs: valid=%h x=%0d y=%0d busy=%b done=%b sof=%b eol=%b state=%0d expected all 0",
               job_if.job_valid, job_if.job_x, job_if.job_y, busy, frame_done, out_sof, out_eol, dbg_state);
    else n_pass++;
    @(negedge aclk);
    aresetn = 1'b1;
    dones = 0;
    repeat (5) begin
      @(negedge aclk);
      if (frame_done) dones++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL midreset_no_done: %0d pulses expected 0", dones);
    else n_pass++;
    run_frame(4, 2, 3, 0, "after_reset");
  endtask

  initial begin
    job_if.job_ready = '0;
    test_reset();
    test_raster_4x2();
    test_two_cores();
    test_extra_clamp();
    test_stall();
    test_random();
    test_zero_width();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
